// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control unit and the write-back mux.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sisc_pkg;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU_R = 4'h1;
  localparam logic [3:0] OP_ALU_I = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_LUI   = 4'h5;
  localparam logic [3:0] OP_BR    = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Write-back mux select, shared with mux32.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'h0;

  // Opcodes 0-7 and HALT are defined; 8-E are undefined and run as NOP.
  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_JAL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluation: cond 0000 is always-taken, else any selected flag set.
// Latency: combinational, zero cycles.
// Backpressure: none.
module sisc_br_eval (
  input  logic [3:0] cond,
  input  logic [3:0] stat,
  output logic       taken
);

  assign taken = (cond == 4'b0000) || ((cond & stat) != 4'b0000);

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control FSM: sequences fetch/decode/execute/mem/wb, drives datapath controls.
// Latency: 3-5 cycles per instruction; outputs are combinational from state plus instr.
// Backpressure: none; instr must be held stable by the IR for the whole instruction.
module sisc_ctrl
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [3:0]  stat,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        stat_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal
);

  state_t     state;
  logic [3:0] opcode;
  logic [3:0] func;
  logic       br_taken;
  logic       unused_instr;

  assign opcode       = instr[31:28];
  assign func         = instr[27:24];
  // Register/immediate fields are consumed by the datapath, not by control.
  assign unused_instr = ^instr[23:0];

  sisc_br_eval u_br_eval (
    .cond  (func),
    .stat  (stat),
    .taken (br_taken)
  );

  // State register: synchronous reset to START, otherwise advance per opcode.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state <= ST_START;
    end else begin
      case (state)
        ST_START:  state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: state <= (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE: begin
          case (opcode)
            OP_LOAD, OP_STORE:                  state <= ST_MEM;
            OP_ALU_R, OP_ALU_I, OP_LUI, OP_JAL: state <= ST_WB;
            default:                            state <= ST_FETCH;
          endcase
        end
        ST_MEM:  state <= (opcode == OP_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_START;
      endcase
    end
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = PC_INC;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    stat_en  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    if (rst_f) begin
      case (state)
        ST_FETCH: begin
          mem_rd   = 1'b1;
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_sel   = PC_INC;
        end
        ST_DECODE: illegal = !op_defined(opcode);
        ST_EXECUTE: begin
          case (opcode)
            OP_ALU_R: begin
              alu_op  = func;
              stat_en = 1'b1;
            end
            OP_ALU_I: begin
              alu_op  = func;
              alu_src = 1'b1;
              stat_en = 1'b1;
            end
            OP_LOAD, OP_STORE: alu_src = 1'b1;
            OP_BR: begin
              if (br_taken) begin
                pc_write = 1'b1;
                pc_sel   = PC_BR;
              end
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_rd = (opcode == OP_LOAD);
          mem_wr = (opcode == OP_STORE);
        end
        ST_WB: begin
          case (opcode)
            OP_ALU_R, OP_ALU_I: begin
              rf_we  = 1'b1;
              wb_sel = WB_ALU;
            end
            OP_LOAD: begin
              rf_we  = 1'b1;
              wb_sel = WB_MEM;
            end
            OP_LUI: begin
              rf_we  = 1'b1;
              wb_sel = WB_IMM;
            end
            OP_JAL: begin
              // Link value is the already-incremented PC, taken before the jump lands.
              rf_we    = 1'b1;
              wb_sel   = WB_PC;
              pc_write = 1'b1;
              pc_sel   = PC_JMP;
            end
            default: ;
          endcase
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: directed scenarios plus randomized instruction stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_sisc_ctrl;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic [31:0] instr = '0;
  logic [3:0]  stat = '0;
  logic        ir_load, pc_write, rf_we, alu_src, stat_en, mem_rd, mem_wr, halted, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [3:0]  alu_op;

  typedef struct packed {
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       stat_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal;
  } ov_t;

  ov_t obs_now;
  ov_t exp_q[$];
  ov_t obs_q[$];
  ov_t next_obs;
  ov_t fetch_v;
  int  checks = 0;
  int  errors = 0;

  assign obs_now = {ir_load, pc_write, pc_sel, rf_we, wb_sel, alu_op,
                    alu_src, stat_en, mem_rd, mem_wr, halted, illegal};

  always #5 clk = ~clk;

  sisc_ctrl dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .instr    (instr),
    .stat     (stat),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .alu_op   (alu_op),
    .alu_src  (alu_src),
    .stat_en  (stat_en),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .halted   (halted),
    .illegal  (illegal)
  );

  // Reference: per-cycle control outputs of one instruction, straight from the opcode table.
  task automatic model(input logic [31:0] ins, input logic [3:0] st);
    ov_t        v;
    logic [3:0] op;
    logic [3:0] cond;
    op   = ins[31:28];
    cond = ins[27:24];
    exp_q.delete();
    exp_q.push_back(fetch_v);
    v = '0;
    v.illegal = (op >= 4'h8) && (op <= 4'hE);
    exp_q.push_back(v);
    if (op == 4'hF) begin
      v = '0; v.halted = 1'b1; exp_q.push_back(v);
    end else if (op == 4'h1 || op == 4'h2) begin
      v = '0; v.alu_op = cond; v.alu_src = (op == 4'h2); v.stat_en = 1'b1; exp_q.push_back(v);
      v = '0; v.rf_we = 1'b1; v.wb_sel = 2'b00; exp_q.push_back(v);
    end else if (op == 4'h3) begin
      v = '0; v.alu_src = 1'b1; exp_q.push_back(v);
      v = '0; v.mem_rd = 1'b1; exp_q.push_back(v);
      v = '0; v.rf_we = 1'b1; v.wb_sel = 2'b01; exp_q.push_back(v);
    end else if (op == 4'h4) begin
      v = '0; v.alu_src = 1'b1; exp_q.push_back(v);
      v = '0; v.mem_wr = 1'b1; exp_q.push_back(v);
    end else if (op == 4'h5) begin
      v = '0; exp_q.push_back(v);
      v = '0; v.rf_we = 1'b1; v.wb_sel = 2'b10; exp_q.push_back(v);
    end else if (op == 4'h6) begin
      v = '0;
      if (cond == 4'h0 || (cond & st) != 4'h0) begin
        v.pc_write = 1'b1; v.pc_sel = 2'b01;
      end
      exp_q.push_back(v);
    end else if (op == 4'h7) begin
      v = '0; exp_q.push_back(v);
      v = '0; v.rf_we = 1'b1; v.wb_sel = 2'b11; v.pc_write = 1'b1; v.pc_sel = 2'b10;
      exp_q.push_back(v);
    end else begin
      v = '0; exp_q.push_back(v);
    end
  endtask

  // Runs one instruction starting in FETCH (just after a falling edge); records every cycle
  // plus the first cycle after it.
  task automatic drive_instr(input logic [31:0] ins, input logic [3:0] st);
    instr = ins;
    stat  = st;
    model(ins, st);
    obs_q.delete();
    #1 obs_q.push_back(obs_now);
    for (int k = 1; k < exp_q.size(); k++) begin
      @(negedge clk); #1;
      obs_q.push_back(obs_now);
    end
    @(negedge clk); #1;
    next_obs = obs_now;
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    instr = 32'h1123_0000;
    stat  = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL reset_hold got %h want 0", obs_now);
    end
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL reset_start got %h want 0", obs_now);
    end
    @(negedge clk); #1;
    checks++;
    if (obs_now !== fetch_v) begin
      errors++; $display("FAIL reset_first_fetch got %h want %h", obs_now, fetch_v);
    end
  endtask

  task automatic test_nop();
    int loads;
    drive_instr(32'h0000_0000, 4'h0);
    loads = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL nop cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].ir_load === 1'b1) loads++;
    end
    checks++;
    if (loads != 1 || next_obs !== fetch_v) begin
      errors++; $display("FAIL nop_cpi ir_loads %0d next %h want 1 %h", loads, next_obs, fetch_v);
    end
  endtask

  task automatic test_alu_r();
    drive_instr(32'h1123_0000, 4'($urandom_range(0, 15)));
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL alu_r cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[2].stat_en !== 1'b1 || obs_q[2].alu_op !== 4'h1 || obs_q[3].rf_we !== 1'b1) begin
      errors++; $display("FAIL alu_r_fields got %h/%h want stat_en alu_op=1 rf_we", obs_q[2], obs_q[3]);
    end
    checks++;
    if (next_obs !== fetch_v) begin
      errors++; $display("FAIL alu_r_cpi next %h want %h", next_obs, fetch_v);
    end
  endtask

  task automatic test_load();
    int wr;
    drive_instr(32'h3012_0004, 4'h0);
    wr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL load cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].mem_wr !== 1'b0) wr++;
    end
    checks++;
    if (wr != 0 || next_obs !== fetch_v || obs_q.size() != 5) begin
      errors++; $display("FAIL load_cpi mem_wr %0d next %h want 0 %h", wr, next_obs, fetch_v);
    end
  endtask

  task automatic test_branch();
    drive_instr(32'h6100_FFFE, 4'b0001);
    checks++;
    if (obs_q[2].pc_write !== 1'b1 || obs_q[2].pc_sel !== 2'b01) begin
      errors++; $display("FAIL br_taken got %h want pc_write=1 pc_sel=01", obs_q[2]);
    end
    checks++;
    if (next_obs !== fetch_v) begin
      errors++; $display("FAIL br_taken_cpi next %h want %h", next_obs, fetch_v);
    end
    drive_instr(32'h6100_FFFE, 4'b1110);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL br_not_taken cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[2].pc_write !== 1'b0) begin
      errors++; $display("FAIL br_not_taken_pcw got %b want 0", obs_q[2].pc_write);
    end
  endtask

  task automatic test_jal_illegal();
    int pulses;
    drive_instr(32'h7300_0040, 4'h0);
    checks++;
    if (obs_q[3] !== exp_q[3] || obs_q[3].wb_sel !== 2'b11 || obs_q[3].pc_sel !== 2'b10) begin
      errors++; $display("FAIL jal_wb got %h want %h", obs_q[3], exp_q[3]);
    end
    drive_instr(32'hA000_0000, 4'h0);
    pulses = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL undef cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].illegal === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || obs_q[1].illegal !== 1'b1 || next_obs !== fetch_v) begin
      errors++; $display("FAIL undef_pulse pulses %0d next %h want 1 %h", pulses, next_obs, fetch_v);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  op;
    for (int n = 0; n < 80; n++) begin
      r  = $urandom();
      op = 4'($urandom_range(0, 14));
      drive_instr({op, r[27:0]}, 4'($urandom_range(0, 15)));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand n%0d op%h cyc%0d got %h want %h", n, op, i, obs_q[i], exp_q[i]);
        end
        checks++;
        if ((obs_q[i].rf_we && obs_q[i].mem_wr) || (obs_q[i].rf_we && obs_q[i].stat_en) ||
            (obs_q[i].mem_wr && obs_q[i].stat_en) || (obs_q[i].mem_rd && obs_q[i].mem_wr)) begin
          errors++; $display("FAIL rand_excl n%0d cyc%0d got %h want exclusive", n, i, obs_q[i]);
        end
      end
      checks++;
      if (next_obs !== fetch_v) begin
        errors++; $display("FAIL rand_cpi n%0d op%h next %h want %h", n, op, next_obs, fetch_v);
      end
    end
  endtask

  task automatic test_halt();
    ov_t hv;
    hv = '0;
    hv.halted = 1'b1;
    drive_instr(32'hF000_0000, 4'h0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_now !== hv) begin
        errors++; $display("FAIL halt_hold cyc%0d got %h want %h", i, obs_now, hv);
      end
      instr = $urandom();
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_load();
    rst_f = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk); #1;
    instr = 32'h3012_0004;
    stat  = 4'h0;
    checks++;
    if (obs_now !== fetch_v) begin
      errors++; $display("FAIL rml_fetch got %h want %h", obs_now, fetch_v);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_now.mem_rd !== 1'b1 || obs_now.ir_load !== 1'b0) begin
      errors++; $display("FAIL rml_in_mem got %h want mem_rd only", obs_now);
    end
    rst_f = 1'b0;
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL rml_gate got %h want 0", obs_now);
    end
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL rml_start got %h want 0", obs_now);
    end
    @(negedge clk); #1;
    checks++;
    if (obs_now !== fetch_v) begin
      errors++; $display("FAIL rml_refetch got %h want %h", obs_now, fetch_v);
    end
    drive_instr(32'h5400_1234, 4'h0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rml_lui cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    fetch_v = '0;
    fetch_v.ir_load  = 1'b1;
    fetch_v.pc_write = 1'b1;
    fetch_v.mem_rd   = 1'b1;
    test_reset();
    test_nop();
    test_alu_r();
    test_load();
    test_branch();
    test_jal_illegal();
    test_random();
    test_halt();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl.md
# sisc_ctrl

Multi-cycle control unit for the SISC processor datapath. It sequences each instruction through fetch, decode, execute, optional memory access and write-back, and drives every datapath control line. This includes the 2-bit write-back select consumed by the 32-bit 4:1 write-back mux, which is the block directly downstream of this one. It holds the only sequential control state in the core; the datapath itself is steered purely by this block's outputs.

## Interface
Parameters:
- none; encodings are fixed constants in the shared package.

Ports:
- clk: input, 1 bit. Single clock; all state updates on the rising edge.
- rst_f: input, 1 bit. Reset is synchronous and active-low.
- instr: input, 32 bits. Current instruction from the IR. Fields:
  - opcode [31:28]
  - func/cond [27:24]
  - rd [23:20]
  - rs [19:16]
  - rt [15:12]
  - imm [15:0]
- stat: input, 4 bits. Status register {C,N,V,Z} from the ALU status latch.
- ir_load: output, 1 bit. IR captures memory data this cycle.
- pc_write: output, 1 bit. PC updates this cycle.
- pc_sel: output, 2 bits. PC source:
  - 00: PC+1
  - 01: PC+1+sext(imm)
  - 10: zext(imm)
- rf_we: output, 1 bit. Register file write enable; write port address is rd.
- wb_sel: output, 2 bits. Write-back mux select:
  - 00: ALU result
  - 01: memory data
  - 10: {imm,16'h0}
  - 11: PC (already incremented)
- alu_op: output, 4 bits. Equals instr[27:24] in EXECUTE for ALU classes; 4'h0 (ADD) otherwise.
- alu_src: output, 1 bit. 0 = rt operand, 1 = sext(imm).
- stat_en: output, 1 bit. Status register loads ALU flags this cycle.
- mem_rd: output, 1 bit. Data memory read strobe.
- mem_wr: output, 1 bit. Data memory write strobe.
- halted: output, 1 bit. High while in HALT.
- illegal: output, 1 bit. One-cycle pulse in DECODE for an undefined opcode.

## Operation
- State register encodings: START, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- Outputs are a combinational function of the registered state plus instr. Every output is 0 in START and whenever rst_f=0.
- Transitions:
  - START→FETCH
  - FETCH→DECODE
  - DECODE→HALT if opcode=1111, else EXECUTE
  - EXECUTE→MEM for LOAD/STORE; EXECUTE→WB for ALU-R, ALU-I, LUI, JAL; EXECUTE→FETCH for NOP, BR, undefined
  - MEM→WB for LOAD; MEM→FETCH for STORE
  - WB→FETCH
  - HALT→HALT
- FETCH: mem_rd=1, ir_load=1, pc_write=1, pc_sel=00.
- Opcode behaviour:
  - 0000 NOP: no outputs beyond FETCH.
  - 0001 ALU-R: EXECUTE alu_src=0, stat_en=1. WB rf_we=1, wb_sel=00.
  - 0010 ALU-I: as ALU-R but alu_src=1.
  - 0011 LOAD: EXECUTE alu_src=1 (address rs+imm). MEM mem_rd=1. WB rf_we=1, wb_sel=01.
  - 0100 STORE: EXECUTE alu_src=1. MEM mem_wr=1. No write-back.
  - 0101 LUI: WB rf_we=1, wb_sel=10.
  - 0110 BR: taken when cond=0000 or (cond & stat)≠0. If taken, EXECUTE pc_write=1, pc_sel=01; if not taken, nothing.
  - 0111 JAL: WB rf_we=1, wb_sel=11, plus pc_write=1, pc_sel=10 in the same cycle. The link value is the pre-jump PC.
  - 1111 HALT.
  - Any other opcode: illegal=1 in DECODE, then executes as NOP.
- Ordering: stat_en asserts only in EXECUTE, so a BR that follows in the next instruction sees the updated flags.
- Exclusivity: rf_we, mem_wr and stat_en are never asserted in the same cycle. mem_rd and mem_wr are never both 1.

## Timing
- Reset: when rst_f=0 at a rising edge, the state becomes START next cycle, regardless of current state (including HALT or mid-MEM). All outputs read 0 while rst_f=0.
- First fetch occurs on the 2nd edge after rst_f rises.
- Cycles per instruction (FETCH inclusive):
  - NOP, BR, undefined: 3
  - ALU-R, ALU-I, LUI, JAL: 4
  - STORE: 4
  - LOAD: 5
- instr must be stable from the edge ending FETCH through the last state of the instruction; the block does not latch it.
- The only exit from HALT is reset.

## Structure
- Package sisc_pkg holds:
  - the state enum
  - opcode constants
  - wb_sel and pc_sel encodings
  - the ALU ADD code
- The shared mux32 uses the wb_sel encoding from this package.
- One sub-module is natural: sisc_br_eval, combinational (cond, stat) → taken.
- Everything else is a single state register plus an output decode block.

## Test plan
- Reset then NOP (instr=32'h0): after rst_f rises, the trace is START, FETCH, DECODE, EXECUTE, FETCH. ir_load=1 only in FETCH.
- ALU-R (instr=32'h1123_0000): WB asserts rf_we=1 and wb_sel=00. EXECUTE asserts stat_en=1 and alu_op=1. Instruction takes 4 cycles total.
- LOAD (instr=32'h3012_0004): MEM asserts mem_rd=1, then WB asserts rf_we=1 and wb_sel=01. Total 5 cycles; mem_wr stays 0 throughout.
- BR with cond=0001 (instr=32'h6100_FFFE): with stat=4'b0001, EXECUTE asserts pc_write=1, pc_sel=01. With stat=4'b1110, pc_write=0.
- JAL (instr=32'h7300_0040), then undefined opcode (32'hA000_0000): JAL's WB asserts rf_we=1, wb_sel=11, pc_write=1, pc_sel=10. The undefined opcode pulses illegal for one cycle in DECODE and returns to FETCH after EXECUTE.
- HALT (32'hF000_0000), then reset mid-LOAD: after HALT, halted stays 1 for ≥10 cycles. Dropping rst_f during MEM gives START on the next edge with all outputs 0.
